// File: rtl/ranger_pkg.sv
// Shared types, 100 MHz default timing and the bar thermometer encoder
// for the multi-channel ultrasonic ranger.
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    localparam int DEF_N_CH      = 4;
    localparam int DEF_CNT_W     = 20;
    localparam int DEF_TRIG_CYC  = 1000;
    localparam int DEF_RISE_TO   = 100000;
    localparam int DEF_MAX_CYC   = 600000;
    localparam int DEF_GAP_CYC   = 6000000;
    localparam int DEF_BASE      = 6029;
    localparam int DEF_CRASH_CYC = 6029;

    // One extra lit segment for every bucket bound (base<<i) the count exceeds.
    function automatic logic [7:0] bar_encode(input logic [31:0] c, input logic [31:0] base);
        logic [7:0] b;
        b = 8'h01;
        for (int i = 0; i < 7; i++) begin
            if (c > (base << i)) begin
                b = {b[6:0], 1'b1};
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/ranger_sync2.sv
// Two-flop synchronizer for the raw echo pins, reset to 0.
module ranger_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin multi-sensor ultrasonic ranger: fires one sensor at a time,
// times its echo, reports results/timeouts and keeps a per-channel bar and crash flag.
module ultrasonic_ranger_mc
    import ranger_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TRIG_CYC  = DEF_TRIG_CYC,
    parameter int RISE_TO   = DEF_RISE_TO,
    parameter int MAX_CYC   = DEF_MAX_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int BASE      = DEF_BASE,
    parameter int CRASH_CYC = DEF_CRASH_CYC,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trigger,
    output logic              dist_valid,
    output logic [CH_W-1:0]   dist_ch,
    output logic [CNT_W-1:0]  dist_cnt,
    output logic              dist_err,
    output logic [8*N_CH-1:0] bar,
    output logic [N_CH-1:0]   crash
);

    localparam int T01  = (TRIG_CYC > RISE_TO) ? TRIG_CYC : RISE_TO;
    localparam int T23  = (MAX_CYC > GAP_CYC) ? MAX_CYC : GAP_CYC;
    localparam int TMAX = (T01 > T23) ? T01 : T23;
    localparam int TW   = $clog2(TMAX + 1);

    state_t            state_reg, state_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CH_W-1:0]   ch_reg, ch_next;
    logic              stuck_reg, stuck_next;
    logic [N_CH-1:0]   trigger_reg, trigger_next;
    logic              dist_valid_reg;
    logic [CH_W-1:0]   dist_ch_reg;
    logic [CNT_W-1:0]  dist_cnt_reg;
    logic              dist_err_reg;

    logic [N_CH-1:0]   echo_s;
    logic [N_CH-1:0]   ch_sel;
    logic              echo_cur;
    logic              rep_valid;
    logic              rep_err;

    ranger_sync2 #(.W(N_CH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (echo),
        .q     (echo_s)
    );

    assign echo_cur = |(echo_s & ch_sel);

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg + 1'b1;
        count_next = count_reg;
        ch_next    = ch_reg;
        stuck_next = stuck_reg;
        rep_valid  = 1'b0;
        rep_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (enable) begin
                    state_next = TRIG;
                end
            end
            TRIG: begin
                // Echo already high as the trigger starts: sensor stuck, report now.
                if (timer_reg == '0) begin
                    stuck_next = echo_cur;
                    rep_valid  = echo_cur;
                    rep_err    = echo_cur;
                end
                if (timer_reg == TW'(TRIG_CYC - 1)) begin
                    timer_next = '0;
                    state_next = stuck_next ? HOLDOFF : WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (echo_cur) begin
                    state_next = MEASURE;
                    count_next = CNT_W'(1);
                    timer_next = '0;
                end else if (timer_reg == TW'(RISE_TO)) begin
                    rep_valid  = 1'b1;
                    rep_err    = 1'b1;
                    state_next = HOLDOFF;
                    timer_next = '0;
                end
            end
            MEASURE: begin
                timer_next = '0;
                if (echo_cur) begin
                    if (count_reg == CNT_W'(MAX_CYC - 1)) begin
                        rep_valid  = 1'b1;
                        rep_err    = 1'b1;
                        state_next = HOLDOFF;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end else begin
                    rep_valid  = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (timer_reg == TW'(GAP_CYC - 1)) begin
                    timer_next = '0;
                    ch_next    = (ch_reg == CH_W'(N_CH - 1)) ? '0 : ch_reg + 1'b1;
                    state_next = enable ? TRIG : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            count_reg      <= '0;
            ch_reg         <= '0;
            stuck_reg      <= 1'b0;
            trigger_reg    <= '0;
            dist_valid_reg <= 1'b0;
            dist_ch_reg    <= '0;
            dist_cnt_reg   <= '0;
            dist_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            count_reg      <= count_next;
            ch_reg         <= ch_next;
            stuck_reg      <= stuck_next;
            trigger_reg    <= trigger_next;
            dist_valid_reg <= rep_valid;
            if (rep_valid) begin
                dist_ch_reg  <= ch_reg;
                dist_cnt_reg <= rep_err ? '1 : count_reg;
                dist_err_reg <= rep_err;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [7:0] bar_reg;
            logic       crash_reg;

            assign ch_sel[gi]       = (ch_reg == CH_W'(gi));
            assign trigger_next[gi] = (state_next == TRIG) && (ch_next == CH_W'(gi));

            // Errors leave the last good reading on display.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bar_reg   <= '0;
                    crash_reg <= 1'b0;
                end else if (rep_valid && !rep_err && ch_sel[gi]) begin
                    bar_reg   <= bar_encode(32'(count_reg), 32'(BASE));
                    crash_reg <= (count_reg <= CNT_W'(CRASH_CYC));
                end
            end

            assign bar[8*gi +: 8] = bar_reg;
            assign crash[gi]      = crash_reg;
        end
    endgenerate

    assign trigger    = trigger_reg;
    assign dist_valid = dist_valid_reg;
    assign dist_ch    = dist_ch_reg;
    assign dist_cnt   = dist_cnt_reg;
    assign dist_err   = dist_err_reg;

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Directed bench for ultrasonic_ranger_mc with short timing constants.
module tb_ultrasonic_ranger_mc;

    localparam int N_CH      = 2;
    localparam int CNT_W     = 20;
    localparam int TRIG_CYC  = 10;
    localparam int RISE_TO   = 50;
    localparam int MAX_CYC   = 400;
    localparam int GAP_CYC   = 20;
    localparam int BASE      = 8;
    localparam int CRASH_CYC = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [1:0]       echo;
    logic [1:0]       trigger;
    logic             dist_valid;
    logic [0:0]       dist_ch;
    logic [CNT_W-1:0] dist_cnt;
    logic             dist_err;
    logic [15:0]      bar;
    logic [1:0]       crash;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int echo_left [2];
    int t_fall;
    logic [1:0]       first_trig;
    logic [0:0]       cap_ch;
    logic [CNT_W-1:0] cap_cnt;
    logic             cap_err;

    ultrasonic_ranger_mc #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .TRIG_CYC  (TRIG_CYC),
        .RISE_TO   (RISE_TO),
        .MAX_CYC   (MAX_CYC),
        .GAP_CYC   (GAP_CYC),
        .BASE      (BASE),
        .CRASH_CYC (CRASH_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .echo       (echo),
        .trigger    (trigger),
        .dist_valid (dist_valid),
        .dist_ch    (dist_ch),
        .dist_cnt   (dist_cnt),
        .dist_err   (dist_err),
        .bar        (bar),
        .crash      (crash)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each channel's echo stays high for echo_left negedge-to-negedge periods.
    initial begin
        echo = 2'b00;
        echo_left[0] = 0;
        echo_left[1] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (echo_left[c] > 0) begin
                    echo[c] = 1'b1;
                    echo_left[c] = echo_left[c] - 1;
                end else begin
                    echo[c] = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Waits for trigger[ch] to rise, measures its width, notes any report seen meanwhile.
    task automatic trig_pulse(input int ch, output int width, output bit saw_valid);
        int n;
        n = 0;
        width = 0;
        saw_valid = 1'b0;
        while (trigger[ch[0]] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("trig_rise_timeout", 32'(n < 300), 32'(1));
        first_trig = trigger;
        while (trigger[ch[0]] === 1'b1 && width < 100) begin
            if (dist_valid === 1'b1) begin
                saw_valid = 1'b1;
                cap_ch  = dist_ch;
                cap_cnt = dist_cnt;
                cap_err = dist_err;
            end
            width++;
            @(negedge clk);
        end
        t_fall = cyc;
        $display("trigger ch=%0d width=%0d", ch, width);
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (dist_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_val("valid_timeout", 32'(n < bound), 32'(1));
        $display("report ch=%0d cnt=%0h err=%0b bar=%04h crash=%02b",
                 dist_ch, dist_cnt, dist_err, bar, crash);
    endtask

    initial begin
        int  w;
        bit  sv;
        int  n;

        repeat (3) @(negedge clk);
        check_val("rst_trigger", 32'(trigger), 32'(0));
        check_val("rst_valid", 32'(dist_valid), 32'(0));
        check_val("rst_cnt", 32'(dist_cnt), 32'(0));
        check_val("rst_bar", 32'(bar), 32'(0));
        check_val("rst_crash", 32'(crash), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // ch0, 8-cycle echo: exactly BASE -> first bar segment, crash set
        trig_pulse(0, w, sv);
        check_val("t1_trig_width", 32'(w), 32'(10));
        check_val("t1_trig_onehot", 32'(first_trig), 32'(2'b01));
        echo_left[0] = 8;
        wait_valid(100);
        check_val("t1_ch", 32'(dist_ch), 32'(0));
        check_val("t1_cnt", 32'(dist_cnt), 32'(8));
        check_val("t1_err", 32'(dist_err), 32'(0));
        check_val("t1_bar0", 32'(bar[7:0]), 32'(8'h01));
        check_val("t1_crash0", 32'(crash[0]), 32'(1));
        @(negedge clk);
        check_val("t1_valid_pulse", 32'(dist_valid), 32'(0));

        // ch1, 9 cycles: BASE+1 -> two segments, no crash
        trig_pulse(1, w, sv);
        check_val("t2_trig_width", 32'(w), 32'(10));
        check_val("t2_trig_onehot", 32'(first_trig), 32'(2'b10));
        echo_left[1] = 9;
        wait_valid(100);
        check_val("t2_ch", 32'(dist_ch), 32'(1));
        check_val("t2_cnt", 32'(dist_cnt), 32'(9));
        check_val("t2_err", 32'(dist_err), 32'(0));
        check_val("t2_bar1", 32'(bar[15:8]), 32'(8'h03));
        check_val("t2_crash1", 32'(crash[1]), 32'(0));
        check_val("t2_bar0_kept", 32'(bar[7:0]), 32'(8'h01));

        // ch0, 65 cycles: exceeds 8,16,32,64 -> 0x1F
        trig_pulse(0, w, sv);
        echo_left[0] = 65;
        wait_valid(200);
        check_val("t2b_cnt", 32'(dist_cnt), 32'(65));
        check_val("t2b_bar0", 32'(bar[7:0]), 32'(8'h1F));
        check_val("t2b_crash0", 32'(crash[0]), 32'(0));

        // ch1, 513-cycle echo: long-echo error, bar untouched
        trig_pulse(1, w, sv);
        echo_left[1] = 513;
        wait_valid(600);
        check_val("t2c_ch", 32'(dist_ch), 32'(1));
        check_val("t2c_err", 32'(dist_err), 32'(1));
        check_val("t2c_cnt", 32'(dist_cnt), 32'(20'hFFFFF));
        check_val("t2c_bar1_kept", 32'(bar[15:8]), 32'(8'h03));

        // ch0 silent (echo1 still high and must be ignored): timeout 51 cycles after trigger fall
        trig_pulse(0, w, sv);
        check_val("t3_trig_width", 32'(w), 32'(10));
        wait_valid(100);
        check_val("t3_latency", 32'(cyc - t_fall), 32'(51));
        check_val("t3_ch", 32'(dist_ch), 32'(0));
        check_val("t3_err", 32'(dist_err), 32'(1));
        check_val("t3_cnt", 32'(dist_cnt), 32'(20'hFFFFF));
        check_val("t3_bar0_kept", 32'(bar[7:0]), 32'(8'h1F));

        // echo1 high before its trigger: stuck error while trigger still completes
        echo_left[1] = 1000;
        trig_pulse(1, w, sv);
        check_val("t4_trig_width", 32'(w), 32'(10));
        check_val("t4_saw_report", 32'(sv), 32'(1));
        check_val("t4_ch", 32'(cap_ch), 32'(1));
        check_val("t4_err", 32'(cap_err), 32'(1));
        check_val("t4_cnt", 32'(cap_cnt), 32'(20'hFFFFF));
        echo_left[1] = 0;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (dist_valid === 1'b1) n++;
        end
        check_val("t4_no_extra_report", 32'(n), 32'(0));

        // enable drops mid-measure: result still reported, then idle
        trig_pulse(0, w, sv);
        echo_left[0] = 30;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_valid(100);
        check_val("t5_cnt", 32'(dist_cnt), 32'(30));
        check_val("t5_bar0", 32'(bar[7:0]), 32'(8'h07));
        check_val("t5_crash0", 32'(crash[0]), 32'(0));
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (trigger !== 2'b00) n++;
        end
        check_val("t5_no_trigger", 32'(n), 32'(0));

        // async reset during ch1 trigger, then restart from ch0
        enable = 1'b1;
        n = 0;
        while (trigger === 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_trig_ch1", 32'(trigger), 32'(2'b10));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_trig_drop", 32'(trigger), 32'(0));
        check_val("t6_bar_clr", 32'(bar), 32'(0));
        check_val("t6_cnt_clr", 32'(dist_cnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (trigger === 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_restart_ch0", 32'(trigger), 32'(2'b01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
